prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4096, meaning the largest word count accepted into instruction memory.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid from the host link.
REQ-005 SHALL have port in_data  input  8  byte-stream data.
REQ-006 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high on a clk edge.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-008 SHALL have port imem_addr  output  32  byte address of the word being written.
REQ-009 SHALL have port imem_di  output  32  word written to instruction memory.
REQ-010 SHALL have port core_hold  output  1  high keeps the core in reset until the load completes.
REQ-011 SHALL have port done  output  1  load completed successfully (sticky).
REQ-012 SHALL have port error  output  1  load aborted (sticky).

Function
REQ-013 Stream format SHALL be: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
REQ-014 States SHALL be HDR, DATA, WRITE, CHK (macro only), DONE and ERR.
REQ-015 HDR SHALL accept 4 bytes; after the 4th: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-016 DATA SHALL accept 4 bytes; byte k of a word SHALL land in bits [8k+7:8k]; after the 4th byte -> WRITE.
REQ-017 WRITE SHALL last exactly one cycle with imem_we=1, in_ready=0, imem_addr=4*word_index, imem_di=assembled word.
REQ-018 The first word SHALL be written to address 0; imem_addr SHALL advance by 4 per word and never wrap within a legal load.
REQ-019 After WRITE, the state SHALL return to DATA if words remain; otherwise it SHALL go to CHK (macro) or DONE.
REQ-020 Latency SHALL be: imem_we is high on the cycle immediately after the 4th byte of a word is accepted.
REQ-021 in_ready SHALL be 1 in HDR, DATA and CHK, and 0 in WRITE, DONE and ERR.
REQ-022 core_hold SHALL be 1 in every state except DONE.
REQ-023 imem_we SHALL be 0 outside WRITE; imem_addr and imem_di SHALL hold their last values outside WRITE.
REQ-024 DONE and ERR SHALL be terminal until rst; bytes offered there SHALL be ignored.
REQ-025 A stalled in_valid mid-word SHALL preserve the partial word and the byte counter indefinitely.

Reset
REQ-026 rst SHALL asynchronously force: state=HDR, counters=0, checksum=0, in_ready=0 while asserted, imem_we=0, imem_addr=0, imem_di=0, core_hold=1, done=0, error=0.
REQ-027 rst asserted mid-load SHALL discard the partial word and restart at HDR; words already written SHALL remain in memory.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN defined: after the last word, CHK SHALL accept one byte and compare it with the mod-256 sum of all payload bytes (header excluded); equal -> DONE, unequal -> ERR.
REQ-030 Macro PROG_LOADER_CHECKSUM_EN undefined: no CHK state and no checksum register SHALL exist; the block SHALL go to DONE after the last WRITE.
REQ-031 With PROG_LOADER_CHECKSUM_EN defined and N=0, CHK SHALL expect the trailer byte 0x00.

Structure
REQ-032 The shared package SHALL hold the state enum, HDR_BYTES=4, WORD_BYTES=4 and ADDR_STEP=4.
REQ-033 The byte-to-word assembly (byte counter, shift register) SHALL be the sub-module byte_packer; the FSM, word counter and address SHALL live in prog_loader.

Verification
REQ-034 Header 02 00 00 00, payload 13 00 00 00 93 00 10 00 -> imem writes (0, 0x00000013) then (4, 0x00100093); done=1; core_hold=0.
REQ-035 Header 00 00 00 00 -> done=1 with no imem_we pulse (macro off); with macro on, trailer 00 -> done=1.
REQ-036 Header N=MAX_WORDS+1 -> error=1, core_hold=1, no imem_we pulse, in_ready=0.
REQ-037 in_valid toggled randomly with one word 0xDEADBEEF -> a single write (0, 0xDEADBEEF); in_ready=0 during the WRITE cycle.
REQ-038 rst pulsed after 2 payload bytes, then a full 1-word stream -> write to address 0 with the new word only.
REQ-039 Macro on, 1 word 01 02 03 04, trailer 0x0A -> done; trailer 0x0B -> error.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: definitions shared by the program loader.
//   state_t    - loader FSM states. CHK exists only with PROG_LOADER_CHECKSUM_EN.
//   HDR_BYTES  - number of bytes in the word-count header.
//   WORD_BYTES - number of bytes in each payload word.
//   ADDR_STEP  - byte-address increment between consecutive words.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam int          HDR_BYTES  = 4;
    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from an accepted byte stream.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (drops any partial word)
//   byte_en    - a byte is accepted this cycle
//   byte_in    - the accepted byte
//   word_last  - this accepted byte completes a word (combinational)
//   word       - the completed word, valid while word_last is high
// The byte counter and partial word hold their values while byte_en is low,
// so a stalled stream resumes exactly where it stopped.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    // Bytes enter at the top and drift down, so after three bytes the first
    // one sits in [7:0]; the fourth byte is appended directly on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            cnt   <= cnt + 2'd1;
            shreg <= {byte_in, shreg[23:8]};
        end
    end

    assign word_last = byte_en && (cnt == 2'(WORD_BYTES - 1));
    assign word      = {byte_in, shreg};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte stream and writes it into
// instruction memory while holding the core in reset.
// Stream: 4-byte LE word count N, then N 4-byte LE words
// (plus one checksum byte when PROG_LOADER_CHECKSUM_EN is defined).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_data    - byte stream from the host link
//   in_ready            - byte accepted when in_valid && in_ready
//   imem_we/addr/di     - one-cycle instruction-memory write per word
//   core_hold           - keeps the core in reset until the load is done
//   done, error         - sticky completion / abort flags
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (mod-256 payload checksum).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_di,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    state_t          state, state_nx;
    logic            ready_en;   // low until the first edge after reset
    logic [CW-1:0]   nwords;
    logic [CW-1:0]   wcnt;
    logic            acc;
    logic            pk_last;
    logic [31:0]     pk_word;
    logic            last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign acc       = in_valid && in_ready;
    assign last_word = (wcnt == nwords - CW'(1));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .byte_en   (acc && (state == S_HDR || state == S_DATA)),
        .byte_in   (in_data),
        .word_last (pk_last),
        .word      (pk_word)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_HDR: if (acc && pk_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (pk_word == 32'd0)                 state_nx = S_CHK;
`else
                if (pk_word == 32'd0)                 state_nx = S_DONE;
`endif
                else if (pk_word > 32'(MAX_WORDS))    state_nx = S_ERR;
                else                                  state_nx = S_DATA;
            end
            S_DATA:  if (acc && pk_last) state_nx = S_WRITE;
            S_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_nx = last_word ? S_CHK : S_DATA;
`else
                state_nx = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:   if (acc) state_nx = (in_data == csum) ? S_DONE : S_ERR;
`endif
            default: state_nx = state;   // DONE/ERR are terminal
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state)
            S_HDR, S_DATA: in_ready = ready_en;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:         in_ready = ready_en;
`endif
            S_WRITE:       imem_we  = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            S_ERR:         error    = 1'b1;
            default: ;
        endcase
    end

    // Datapath: word count, word index, write address/data.
    // Address and data are captured on the fourth data byte so they are
    // already stable during WRITE and simply hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            nwords    <= '0;
            wcnt      <= '0;
            imem_addr <= '0;
            imem_di   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (state == S_HDR && acc && pk_last)
                nwords <= pk_word[CW-1:0];
            if (state == S_DATA && acc && pk_last) begin
                imem_addr <= 32'(wcnt) * ADDR_STEP;
                imem_di   <= pk_word;
            end
            if (state == S_WRITE)
                wcnt <= wcnt + CW'(1);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Mod-256 sum of payload bytes only; the header is not included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         csum <= '0;
        else if (state == S_DATA && acc) csum <= csum + in_data;
    end
`endif

endmodule
